// File: rtl/spi_mon_pkg.sv
// Shared types and defaults for the SPI byte monitor and the receiver top.
package spi_mon_pkg;

  localparam int unsigned BYTE_W             = 8;
  localparam int unsigned DEF_AVG_LOG2       = 2;
  localparam logic [7:0]  DEF_TH_HIGH        = 8'd30;
  localparam logic [7:0]  DEF_TH_LOW         = 8'd25;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 25_000_000;
  localparam int unsigned DEF_ERR_LIMIT      = 3;

  typedef enum logic [1:0] {
    LINK_IDLE = 2'd0,
    LINK_OK   = 2'd1,
    LINK_LOST = 2'd2
  } link_state_t;

endpackage

// File: rtl/spi_byte_monitor_if.sv
// Byte/error strobe bus from the oversampling receiver into the monitor.
interface spi_byte_monitor_if;
  import spi_mon_pkg::*;

  logic              byte_valid;
  logic [BYTE_W-1:0] byte_data;
  logic              frame_error;

  modport master (output byte_valid, output byte_data, output frame_error);
  modport slave  (input  byte_valid, input  byte_data, input  frame_error);

endinterface

// File: rtl/spi_byte_monitor_sample_window.sv
// Circular sample buffer with running sum over the last 2^AVG_LOG2 bytes.
module sample_window
  import spi_mon_pkg::*;
#(
  parameter int unsigned AVG_LOG2 = DEF_AVG_LOG2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       clear,
  input  logic [BYTE_W-1:0]          data_in,
  output logic [BYTE_W+AVG_LOG2-1:0] sum_out,
  output logic                       full
);

  localparam int unsigned DEPTH  = 1 << AVG_LOG2;
  localparam int unsigned SUM_W  = BYTE_W + AVG_LOG2;
  localparam int unsigned FILL_W = AVG_LOG2 + 1;

  logic [BYTE_W-1:0]   mem_q [DEPTH];
  logic [AVG_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic [SUM_W-1:0]    sum_q, sum_d;
  logic                full_c;
  logic [BYTE_W-1:0]   old_c;

  assign full_c  = (fill_q == FILL_W'(DEPTH));
  assign full    = full_c;
  assign sum_out = sum_q;

  // Next pointer/fill/sum; the evicted sample only counts once the window has wrapped.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    fill_d   = fill_q;
    sum_d    = sum_q;
    old_c    = full_c ? mem_q[wr_ptr_q] : '0;
    if (clear) begin
      wr_ptr_d = '0;
      fill_d   = '0;
      sum_d    = '0;
    end else if (push) begin
      wr_ptr_d = wr_ptr_q + AVG_LOG2'(1);
      fill_d   = full_c ? fill_q : fill_q + FILL_W'(1);
      sum_d    = sum_q + SUM_W'(data_in) - SUM_W'(old_c);
    end
  end

  // Control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      fill_q   <= '0;
      sum_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      fill_q   <= fill_d;
      sum_q    <= sum_d;
    end
  end

  // Sample storage; stale contents are masked by fill after a clear.
  always_ff @(posedge clk) begin
    if (push && !clear) mem_q[wr_ptr_q] <= data_in;
  end

endmodule

// File: rtl/spi_byte_monitor.sv
// Link monitor: windowed average with hysteresis alarm, watchdog and error counters.
module spi_byte_monitor
  import spi_mon_pkg::*;
#(
  parameter int unsigned       AVG_LOG2       = DEF_AVG_LOG2,
  parameter logic [BYTE_W-1:0] TH_HIGH        = DEF_TH_HIGH,
  parameter logic [BYTE_W-1:0] TH_LOW         = DEF_TH_LOW,
  parameter int unsigned       TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned       ERR_LIMIT      = DEF_ERR_LIMIT
) (
  input  logic               clk_in,
  input  logic               rst,
  spi_byte_monitor_if.slave  rx,
  output logic [BYTE_W-1:0]  avg_out,
  output logic               avg_valid,
  output logic               alarm,
  output logic               link_ok,
  output logic [7:0]         err_count,
  output logic [1:0]         led
);

  localparam int unsigned     SUM_W    = BYTE_W + AVG_LOG2;
  localparam int unsigned     TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]      ERR_MAX  = 8'(ERR_LIMIT);

  link_state_t       state_q, state_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [7:0]        consec_q, consec_d;
  logic [7:0]        err_cnt_q, err_cnt_d;
  logic              push_q, push_d;
  logic [BYTE_W-1:0] data_q, data_d;
  logic              upd_q, upd_d;
  logic [BYTE_W-1:0] avg_q, avg_d;
  logic              avg_valid_q, avg_valid_d;
  logic              alarm_q, alarm_d;
  logic              link_ok_q, link_ok_d;
  logic              accept_c, lose_c;
  logic [SUM_W-1:0]  sum_w;
  logic              full_w;
  logic [BYTE_W-1:0] avg_c;

  assign accept_c = rx.byte_valid & ~rx.frame_error;
  assign avg_c    = BYTE_W'(sum_w >> AVG_LOG2);

  sample_window #(.AVG_LOG2(AVG_LOG2)) u_window (
    .clk     (clk_in),
    .rst_n   (rst),
    .push    (push_q),
    .clear   (lose_c),
    .data_in (data_q),
    .sum_out (sum_w),
    .full    (full_w)
  );

  // Link FSM next state and watchdog; both loss causes merge into one transition.
  always_comb begin
    state_d = state_q;
    lose_c  = 1'b0;
    tmo_d   = '0;
    case (state_q)
      LINK_IDLE: if (accept_c) state_d = LINK_OK;
      LINK_OK: begin
        if ((consec_q == ERR_MAX) || ((tmo_q == TMO_LAST) && !accept_c)) begin
          lose_c  = 1'b1;
          state_d = LINK_LOST;
        end else if (!accept_c) begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      LINK_LOST: if (accept_c) state_d = LINK_OK;
      default:   state_d = LINK_IDLE;
    endcase
  end

  // Saturating error counters; an accepted byte breaks the consecutive run.
  always_comb begin
    consec_d  = consec_q;
    err_cnt_d = err_cnt_q;
    if (accept_c) begin
      consec_d = '0;
    end else if (rx.frame_error) begin
      if (consec_q != ERR_MAX) consec_d = consec_q + 8'd1;
      if (err_cnt_q != 8'hFF)  err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  // Input capture, window-update tracking, average and hysteresis alarm.
  always_comb begin
    push_d      = accept_c;
    data_d      = rx.byte_data;
    upd_d       = push_q & ~lose_c;
    avg_valid_d = upd_q & full_w & ~lose_c;
    avg_d       = avg_valid_d ? avg_c : avg_q;
    alarm_d     = alarm_q;
    link_ok_d   = (state_d == LINK_OK);
    if (lose_c) begin
      alarm_d = 1'b0;
    end else if (avg_valid_d) begin
      if (avg_c > TH_HIGH)     alarm_d = 1'b1;
      else if (avg_c < TH_LOW) alarm_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state_q     <= LINK_IDLE;
      tmo_q       <= '0;
      consec_q    <= '0;
      err_cnt_q   <= '0;
      push_q      <= 1'b0;
      data_q      <= '0;
      upd_q       <= 1'b0;
      avg_q       <= '0;
      avg_valid_q <= 1'b0;
      alarm_q     <= 1'b0;
      link_ok_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      consec_q    <= consec_d;
      err_cnt_q   <= err_cnt_d;
      push_q      <= push_d;
      data_q      <= data_d;
      upd_q       <= upd_d;
      avg_q       <= avg_d;
      avg_valid_q <= avg_valid_d;
      alarm_q     <= alarm_d;
      link_ok_q   <= link_ok_d;
    end
  end

  assign avg_out   = avg_q;
  assign avg_valid = avg_valid_q;
  assign alarm     = alarm_q;
  assign link_ok   = link_ok_q;
  assign err_count = err_cnt_q;
  assign led       = ~{link_ok_q, alarm_q};

endmodule
